serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range is 2..32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request to begin an addition.
REQ-005 SHALL have port A, input, WIDTH bits: first operand, sampled only on an accepted start.
REQ-006 SHALL have port B, input, WIDTH bits: second operand, sampled only on an accepted start.
REQ-007 SHALL have port Cin, input, 1 bit: carry-in, sampled only on an accepted start.
REQ-008 SHALL have port S, output, WIDTH bits: registered sum of the last completed addition.
REQ-009 SHALL have port Cout, output, 1 bit: registered carry-out of the last completed addition.
REQ-010 SHALL have port busy, output, 1 bit: high while an addition is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse marking that S and Cout have just been updated.

Function
REQ-012 SHALL implement a three-state machine with states IDLE, RUN and DONE.
REQ-013 SHALL accept start only in IDLE or DONE; start in RUN SHALL be ignored and not queued.
REQ-014 On an accepted start at edge t, the block SHALL do all of the following: load A and B into internal shift registers, load Cin into the carry flip-flop, clear the bit counter, enter RUN, and set busy=1.
REQ-015 In RUN, each edge SHALL form one sum bit and one carry from (A_sh[0], B_sh[0], carry) using one full-adder function: sum = a^b^c, carry = ab|ac|bc.
REQ-016 In RUN, each edge SHALL shift the sum bit into the MSB of an internal result register, shift A_sh and B_sh right by one, update the carry flip-flop, and increment the counter.
REQ-017 Bits SHALL be processed LSB first; exactly WIDTH RUN edges SHALL occur, at edges t+1 .. t+WIDTH.
REQ-018 At edge t+WIDTH, the block SHALL do all of the following: copy the internal result to S, copy the final carry to Cout, set done=1, set busy=0, and enter DONE.
REQ-019 From DONE, the next edge SHALL clear done and return to IDLE, unless start is high at that edge, in which case the sequence of REQ-014 SHALL apply.
REQ-020 The latency from an accepted start to done high SHALL be exactly WIDTH edges; throughput SHALL be one addition per WIDTH+1 cycles with back-to-back starts.
REQ-021 S and Cout SHALL change only at the completion edge and SHALL hold their previous values throughout RUN.
REQ-022 The result SHALL satisfy {Cout,S} = A + B + Cin, evaluated modulo 2^(WIDTH+1).
REQ-023 Changes on A, B or Cin after the start edge SHALL NOT affect the result in progress.
REQ-024 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap during a valid operation.

Reset
REQ-025 rst_n=0 SHALL immediately, without waiting for a clock edge, force all of the following: state=IDLE, S=0, Cout=0, busy=0, done=0, shift registers=0, carry=0, counter=0.
REQ-026 Reset asserted during RUN SHALL abort the addition and produce no done pulse; S and Cout SHALL read 0.
REQ-027 After rst_n rises, start SHALL be accepted on the first rising edge.

Verification (WIDTH=8)
REQ-028 The bench SHALL apply start with A=0x00, B=0x00, Cin=0 at edge t, and SHALL check: busy=1 from t to t+7, done=1 only after edge t+8, S=0x00, Cout=0.
REQ-029 The bench SHALL apply A=0xFF, B=0x01, Cin=0, and SHALL check S=0x00, Cout=1 at done.
REQ-030 The bench SHALL apply A=0xFF, B=0xFF, Cin=1, and SHALL check S=0xFF, Cout=1; it SHALL then apply A=0x5A, B=0x33, Cin=1, and SHALL check S=0x8E, Cout=0.
REQ-031 The bench SHALL pulse start again at edge t+3 of a running addition with different operands, and SHALL check that it is ignored: only the first result appears, and done is seen once.
REQ-032 The bench SHALL hold start high in the DONE cycle with new operands, and SHALL check that the second addition begins immediately and that its done comes 8 edges later, while S keeps the first result until then.
REQ-033 The bench SHALL assert rst_n=0 mid-RUN (between edges), and SHALL check that busy, done, S and Cout go to 0 without a clock edge, that no done appears afterwards, and that a new start after release completes correctly.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands plus carry-in one bit per
// clock, LSB first, through a single full adder. A result appears WIDTH edges
// after an accepted start. It is held in S/Cout until the next completion.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  // Partial result: holds the WIDTH-1 most recent sum bits. The final sum bit
  // is merged in directly at completion, so no register bit is left unused.
  logic [WIDTH-2:0] res_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  logic [1:0]       fa_d;     // {carry, sum} produced by this cycle's bit
  logic [WIDTH-1:0] res_d;    // result register with this cycle's sum bit shifted in
  logic             accept_d; // start is honoured only outside RUN

  // One full-adder cell, returned as {carry, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    logic sum;
    logic cy;
    sum = a ^ b ^ c;
    cy  = (a & b) | (a & c) | (b & c);
    return {cy, sum};
  endfunction

  // Combinational datapath: current bit-slice add and the shifted result.
  always_comb begin
    fa_d     = full_add(a_sh_q[0], b_sh_q[0], carry_q);
    res_d    = {fa_d[0], res_q};
    accept_d = start && ((state_q == IDLE) || (state_q == DONE));
  end

  // Control FSM with its datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= {WIDTH{1'b0}};
      b_sh_q  <= {WIDTH{1'b0}};
      res_q   <= {(WIDTH-1){1'b0}};
      carry_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      s_q     <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (accept_d) begin
      // Operands are captured here only; later input changes have no effect.
      a_sh_q  <= A;
      b_sh_q  <= B;
      carry_q <= Cin;
      res_q   <= {(WIDTH-1){1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      state_q <= RUN;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        RUN: begin
          a_sh_q  <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q  <= {1'b0, b_sh_q[WIDTH-1:1]};
          res_q   <= res_d[WIDTH-1:1];
          carry_q <= fa_d[1];
          cnt_q   <= cnt_q + CNT_ONE;
          if (cnt_q == LAST_CNT) begin
            s_q     <= res_d;
            cout_q  <= fa_d[1];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign S    = s_q;
  assign Cout = cout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       Cin;
  logic [7:0] S;
  logic       Cout;
  logic       busy;
  logic       done;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int done_seen;

  serial_adder #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .S    (S),
    .Cout (Cout),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one start (inputs driven now, accepted at the next edge t), then
  // check every cycle through edge t+8. ps/pc are the previous result that
  // must be held during RUN. inj_at>0 pulses a competing start at edge t+inj_at.
  task automatic run_add(input string tag,
                         input logic [7:0] a, input logic [7:0] b, input logic ci,
                         input logic [7:0] es, input logic ec,
                         input logic [7:0] ps, input logic pc,
                         input int inj_at);
    A = a; B = b; Cin = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = ~a; B = b ^ 8'hA5; Cin = ~ci;   // later input changes must not matter
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      chk($sformatf("%s_busy_t%0d", tag, k), {31'd0, busy}, 32'd1);
      chk($sformatf("%s_done_t%0d", tag, k), {31'd0, done}, 32'd0);
      chk($sformatf("%s_Shold_t%0d", tag, k), {24'd0, S}, {24'd0, ps});
      chk($sformatf("%s_Chold_t%0d", tag, k), {31'd0, Cout}, {31'd0, pc});
      if (inj_at > 0 && k == inj_at - 1) begin
        start = 1'b1; A = 8'h80; B = 8'h80; Cin = 1'b1;
      end
      if (inj_at > 0 && k == inj_at) begin
        start = 1'b0;
      end
    end
    @(posedge clk); #1;
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    chk({tag, "_S"}, {24'd0, S}, {24'd0, es});
    chk({tag, "_Cout"}, {31'd0, Cout}, {31'd0, ec});
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; A = 8'h00; B = 8'h00; Cin = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_S", {24'd0, S}, 32'd0);
    chk("rst_Cout", {31'd0, Cout}, 32'd0);
    #9 rst_n = 1'b1;   // release at t=12, first edge at t=15 must accept start

    run_add("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 0);
    @(posedge clk); #1;
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    run_add("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 0);
    @(posedge clk); #1;
    run_add("ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b1, 0);
    @(posedge clk); #1;
    run_add("5a_33_c", 8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0, 8'hFF, 1'b1, 0);
    @(posedge clk); #1;

    // Start pulsed at edge t+3 while running must be dropped.
    run_add("ignore", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 8'h8E, 1'b0, 3);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    chk("ignore_no_extra_done", done_seen, 0);
    chk("ignore_S_kept", {24'd0, S}, 32'h46);
    chk("ignore_busy_idle", {31'd0, busy}, 32'd0);

    // Back-to-back: start held during the DONE cycle.
    run_add("b2b_1", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 8'h46, 1'b0, 0);
    run_add("b2b_2", 8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1, 8'h30, 1'b0, 0);
    @(posedge clk); #1;

    // Reset in the middle of RUN, between clock edges.
    A = 8'h0F; B = 8'h01; Cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_S", {24'd0, S}, 32'd0);
    chk("mid_rst_Cout", {31'd0, Cout}, 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    chk("post_rst_no_done", done_seen, 0);
    chk("post_rst_S", {24'd0, S}, 32'd0);

    run_add("after_rst", 8'h7F, 8'h80, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 0);
    @(posedge clk); #1;
    chk("final_done_clear", {31'd0, done}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
